// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: FSM states, halt opcode and forward-select encodings
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam logic [6:0] OPC_HALT  = 7'b1111111;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-register view in, stage controls and perf counters out
interface pipeline_hazard_ctrl_if #(parameter int REG_AW = 5, parameter int CNT_W = 16);
  logic [6:0]        ifid_opcode;
  logic [REG_AW-1:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic              ifid_use_rs1, ifid_use_rs2, ifid_branch, branch_taken;
  logic              idex_regwrite, idex_memread, exmem_regwrite, exmem_memread, memwb_regwrite;
  logic              pc_write, ifid_write, idex_bubble, ifid_flush, halted;
  logic [1:0]        forward_a, forward_b;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  modport master (
    output ifid_opcode, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, ifid_branch, branch_taken,
           idex_rs1, idex_rs2, idex_rd, idex_regwrite, idex_memread,
           exmem_rd, exmem_regwrite, exmem_memread, memwb_rd, memwb_regwrite,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, forward_a, forward_b, halted,
           stall_cnt, flush_cnt
  );
  modport slave (
    input  ifid_opcode, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, ifid_branch, branch_taken,
           idex_rs1, idex_rs2, idex_rd, idex_regwrite, idex_memread,
           exmem_rd, exmem_regwrite, exmem_memread, memwb_rd, memwb_regwrite,
    output pc_write, ifid_write, idex_bubble, ifid_flush, forward_a, forward_b, halted,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_unit.sv
// hazard_fwd_unit: combinational load-use/branch hazard detection and EX forwarding selects
module hazard_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
#(parameter int REG_AW = 5) (
  input  logic [REG_AW-1:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd,
  input  logic              ifid_use_rs1, ifid_use_rs2, ifid_branch,
  input  logic              idex_regwrite, idex_memread, exmem_regwrite, exmem_memread, memwb_regwrite,
  output logic              stall,
  output logic [1:0]        fwd_a, fwd_b
);
  function automatic logic hit(input logic [REG_AW-1:0] x, rd, input logic we);
    return we && rd != '0 && rd == x;
  endfunction
  logic load_use, br_haz;
  always_comb begin
    load_use = idex_memread && ((ifid_use_rs1 && hit(ifid_rs1, idex_rd, 1'b1)) ||
                                (ifid_use_rs2 && hit(ifid_rs2, idex_rd, 1'b1)));
    // branches compare in ID, so they also wait on EX results and on loads still in MEM
    br_haz = ifid_branch &&
             ((ifid_use_rs1 && (hit(ifid_rs1, idex_rd, idex_regwrite) || hit(ifid_rs1, exmem_rd, exmem_memread))) ||
              (ifid_use_rs2 && (hit(ifid_rs2, idex_rd, idex_regwrite) || hit(ifid_rs2, exmem_rd, exmem_memread))));
    stall = load_use || br_haz;
    fwd_a = hit(idex_rs1, exmem_rd, exmem_regwrite) ? FWD_EXMEM :
            hit(idex_rs1, memwb_rd, memwb_regwrite) ? FWD_MEMWB : FWD_RF;
    fwd_b = hit(idex_rs2, exmem_rd, exmem_regwrite) ? FWD_EXMEM :
            hit(idex_rs2, memwb_rd, memwb_regwrite) ? FWD_MEMWB : FWD_RF;
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/halt-drain sequencing and saturating perf counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(parameter int REG_AW = 5, parameter int DRAIN_CYCLES = 3, parameter int CNT_W = 16) (
  input logic                  clk,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             stall, run, flush_go, halt_go;
  logic [1:0]       fwd_a, fwd_b;
  hazard_fwd_unit #(.REG_AW(REG_AW)) u_hfu (
    .ifid_rs1(bus.ifid_rs1), .ifid_rs2(bus.ifid_rs2), .idex_rs1(bus.idex_rs1), .idex_rs2(bus.idex_rs2),
    .idex_rd(bus.idex_rd), .exmem_rd(bus.exmem_rd), .memwb_rd(bus.memwb_rd),
    .ifid_use_rs1(bus.ifid_use_rs1), .ifid_use_rs2(bus.ifid_use_rs2), .ifid_branch(bus.ifid_branch),
    .idex_regwrite(bus.idex_regwrite), .idex_memread(bus.idex_memread),
    .exmem_regwrite(bus.exmem_regwrite), .exmem_memread(bus.exmem_memread),
    .memwb_regwrite(bus.memwb_regwrite), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  always_comb begin
    run         = state_q == ST_RUN;
    flush_go    = run && !stall && bus.ifid_branch && bus.branch_taken;
    halt_go     = run && !stall && !flush_go && bus.ifid_opcode == OPC_HALT;
    state_d     = halt_go ? ST_DRAIN : (state_q == ST_DRAIN && drain_q == '0) ? ST_DONE : state_q;
    drain_d     = halt_go ? DW'(DRAIN_CYCLES - 1) :
                  (state_q == ST_DRAIN && drain_q != '0) ? drain_q - DW'(1) : drain_q;
    stall_cnt_d = (run && stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_go && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end
  // outputs are forced to their idle values combinationally while reset is held low
  always_comb begin
    bus.pc_write    = !reset || (run && !stall);
    bus.ifid_write  = !reset || (run && !stall);
    bus.idex_bubble = !reset || !run || stall || halt_go;
    bus.ifid_flush  = reset && flush_go;
    bus.forward_a   = reset ? fwd_a : FWD_RF;
    bus.forward_b   = reset ? fwd_b : FWD_RF;
    bus.halted      = state_q == ST_DONE;
    bus.stall_cnt   = stall_cnt_q;
    bus.flush_cnt   = flush_cnt_q;
  end
endmodule
